imm_enc: RTL and testbench
==========================

# imm_enc

Immediate encoder for the datapath's constant path, the inverse of the 16→32 immediate extender. It takes a 32-bit constant or branch byte offset and emits the 16-bit immediate plus extender opcode (EOp) that reproduce it. If no single encoding exists, it emits a two-beat lui/ori pair. It sits ahead of the instruction-assembly stage and uses valid/ready handshakes on both sides.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clk is the single clock
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid && in_ready at a clk edge
- in_value  in  32  constant, or byte offset when in_kind=1
- in_kind  in  1  0 = constant, 1 = branch byte offset
- out_valid  out  1  beat present
- out_ready  in  1  beat consumed when out_valid && out_ready at a clk edge
- out_imm  out  16  immediate field
- out_eop  out  2  00 sign-ext, 01 zero-ext, 10 upper (imm<<16), 11 sign-ext then <<2
- out_last  out  1  final beat of the current request
- out_err  out  1  request not encodable; beat carries imm=0000, eop=00
- err_cnt  out  8  saturating count of errored requests

## Operation
- States: IDLE (no beat held), BEAT0 (first or only beat held), BEAT1 (ori beat held).
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last), combinational. This gives back-to-back acceptance with no bubble.
- On accept, compute the encoding, register all out_* fields and enter BEAT0.
- Constant (kind=0), first match wins:
  - value[31:15] all equal → imm=value[15:0], eop=00, last=1
  - value[31:16]==0 → imm=value[15:0], eop=01, last=1
  - value[15:0]==0 → imm=value[31:16], eop=10, last=1
  - otherwise two beats: beat0 imm=value[31:16], eop=10, last=0; beat1 imm=value[15:0], eop=01, last=1
- Branch (kind=1):
  - value[1:0]==00 and value[31:17] all equal → imm=value[17:2], eop=11, last=1
  - otherwise out_err=1, imm=0000, eop=00, last=1; err_cnt increments, saturating at FF
- Transitions:
  - BEAT0 consumed with last=0 → BEAT1 (load the held low half)
  - BEAT0/BEAT1 consumed with last=1 → BEAT0 if a new request is accepted in the same edge, else IDLE
  - not consumed → hold state
- The low half for beat1 is captured at accept into an internal register. in_value need not be held after the handshake.

## Timing
- Latency: accept at edge N → out_valid high after edge N, first beat visible in cycle N+1.
- A two-beat request occupies at least 2 output cycles. Single-beat requests sustain 1 per cycle.
- While out_valid=1 && out_ready=0, out_imm/out_eop/out_last/out_err stay stable (AXI-style hold).
- out_valid never drops without a handshake.
- Simultaneous consume of a last beat and accept: the new beat replaces the old one at the same edge; no idle cycle.
- Reset (any time, including mid-BEAT1): immediately forces IDLE. The pending request is discarded.
  - out_valid=0, out_imm=0000, out_eop=00, out_last=0, out_err=0, err_cnt=00
  - in_ready=1 once in IDLE
- err_cnt updates at the accept edge of the erroring request.

## Test plan
- Constant singles: 0xFFFF8000 → 8000/00/last1; 0x0000ABCD → ABCD/01; 0x00007FFF → 7FFF/00 (sign priority); 0x12340000 → 1234/10; one beat each, in cycle N+1.
- Two-beat with backpressure: 0x12345678 with out_ready low for 3 cycles on beat0 → 1234/10/last0 held stable, then 5678/01/last1; in_ready low until the beat1 handshake.
- Back-to-back: 4 singles with in_valid and out_ready held high → 4 consecutive beats, in_ready constantly 1, no bubbles.
- Branch: 0xFFFFFFF8 → FFFE/11; 0x0001FFFC → 7FFF/11; 0x00000006 and 0x00020000 → out_err=1, 0000/00, err_cnt 0→2.
- err_cnt saturation: 300 bad offsets → err_cnt=FF, no wrap.
- Reset mid-operation: assert reset while BEAT1 is pending (0xDEADBEEF) → out_valid 0 asynchronously, all outputs reset; after release, 0x00000001 → 0001/00 single beat.

Source files
------------

// File: rtl/imm_enc.sv
// Immediate encoder: turns a 32-bit constant or branch byte offset into the
// 16-bit immediate plus extender opcode, splitting into a lui/ori pair if needed.
module imm_enc (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    input  logic        in_kind,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_imm,
    output logic [1:0]  out_eop,
    output logic        out_last,
    output logic        out_err,
    output logic [7:0]  err_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
    localparam logic [1:0] BEAT1 = 2'd2;

    localparam logic [1:0] EOP_SEXT  = 2'b00;
    localparam logic [1:0] EOP_ZEXT  = 2'b01;
    localparam logic [1:0] EOP_UPPER = 2'b10;
    localparam logic [1:0] EOP_BR    = 2'b11;

    logic [1:0]  state_q, state_d;
    logic        valid_q, valid_d;
    logic [15:0] imm_q, imm_d;
    logic [1:0]  eop_q, eop_d;
    logic        last_q, last_d;
    logic        err_q, err_d;
    logic [15:0] lo_q, lo_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [15:0] enc_imm_s;
    logic [1:0]  enc_eop_s;
    logic        enc_last_s;
    logic        enc_err_s;
    logic        consume_s;
    logic        accept_s;

    // Encoding of the incoming request, first matching form wins.
    always_comb begin
        enc_imm_s  = 16'h0000;
        enc_eop_s  = EOP_SEXT;
        enc_last_s = 1'b1;
        enc_err_s  = 1'b0;
        if (!in_kind) begin
            if ((&in_value[31:15]) || !(|in_value[31:15])) begin
                enc_imm_s = in_value[15:0];
                enc_eop_s = EOP_SEXT;
            end else if (!(|in_value[31:16])) begin
                enc_imm_s = in_value[15:0];
                enc_eop_s = EOP_ZEXT;
            end else if (!(|in_value[15:0])) begin
                enc_imm_s = in_value[31:16];
                enc_eop_s = EOP_UPPER;
            end else begin
                enc_imm_s  = in_value[31:16];
                enc_eop_s  = EOP_UPPER;
                enc_last_s = 1'b0;
            end
        end else begin
            if ((in_value[1:0] == 2'b00) &&
                ((&in_value[31:17]) || !(|in_value[31:17]))) begin
                enc_imm_s = in_value[17:2];
                enc_eop_s = EOP_BR;
            end else begin
                enc_err_s = 1'b1;
            end
        end
    end

    // Handshake decode: a last beat leaving frees the slot in the same edge.
    always_comb begin
        consume_s = valid_q && out_ready;
        in_ready  = (state_q == IDLE) || (consume_s && last_q);
        accept_s  = in_valid && in_ready;
    end

    // Next-state and output-register loading.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        imm_d   = imm_q;
        eop_d   = eop_q;
        last_d  = last_q;
        err_d   = err_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        if (accept_s) begin
            state_d = BEAT0;
            valid_d = 1'b1;
            imm_d   = enc_imm_s;
            eop_d   = enc_eop_s;
            last_d  = enc_last_s;
            err_d   = enc_err_s;
            lo_d    = in_value[15:0];
        end else if (consume_s) begin
            if (!last_q) begin
                state_d = BEAT1;
                imm_d   = lo_q;
                eop_d   = EOP_ZEXT;
                last_d  = 1'b1;
                err_d   = 1'b0;
            end else begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        end else begin
            state_d = state_q;
        end
        if (accept_s && enc_err_s && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            imm_q   <= 16'h0000;
            eop_q   <= 2'b00;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            lo_q    <= 16'h0000;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            imm_q   <= imm_d;
            eop_q   <= eop_d;
            last_q  <= last_d;
            err_q   <= err_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_imm   = imm_q;
    assign out_eop   = eop_q;
    assign out_last  = last_q;
    assign out_err   = err_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_imm_enc.sv
// Bench for imm_enc: queue-based reference model checked every cycle, plus
// directed vectors with hand-computed expectations.
module tb_imm_enc;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_value = 32'h0;
    logic        in_kind = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_imm;
    logic [1:0]  out_eop;
    logic        out_last;
    logic        out_err;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [15:0] imm;
        logic [1:0]  eop;
        logic        last;
        logic        err;
    } beat_t;

    beat_t q[$];
    int    err_m = 0;

    imm_enc dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .in_kind(in_kind),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_eop(out_eop), .out_last(out_last),
        .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    function automatic beat_t mk(input logic [15:0] imm, input logic [1:0] eop,
                                 input logic last, input logic err);
        beat_t b;
        b.imm = imm; b.eop = eop; b.last = last; b.err = err;
        return b;
    endfunction

    // Reference encoding from the arithmetic meaning of each extender op.
    task automatic model_push(input logic [31:0] v, input logic k);
        logic signed [31:0] sv;
        logic signed [31:0] sh;
        sv = v;
        if (!k) begin
            if (sv >= -32768 && sv <= 32767)      q.push_back(mk(v[15:0], 2'b00, 1'b1, 1'b0));
            else if (v < 32'h0001_0000)           q.push_back(mk(v[15:0], 2'b01, 1'b1, 1'b0));
            else if ((v % 32'd65536) == 32'd0)    q.push_back(mk(v[31:16], 2'b10, 1'b1, 1'b0));
            else begin
                q.push_back(mk(v[31:16], 2'b10, 1'b0, 1'b0));
                q.push_back(mk(v[15:0], 2'b01, 1'b1, 1'b0));
            end
        end else begin
            if ((v % 32'd4) == 32'd0 && sv >= -131072 && sv <= 131071) begin
                sh = sv / 4;
                q.push_back(mk(sh[15:0], 2'b11, 1'b1, 1'b0));
            end else begin
                q.push_back(mk(16'h0000, 2'b00, 1'b1, 1'b1));
                if (err_m < 255) err_m++;
            end
        end
    endtask

    function automatic bit model_ready();
        return (q.size() == 0) || (q.size() == 1 && out_ready);
    endfunction

    task automatic model_step();
        bit acc;
        acc = in_valid && model_ready();
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (acc) model_push(in_value, in_kind);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            err_m = 0;
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset) begin
            check("m_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
            check("m_in_ready", {31'b0, in_ready}, {31'b0, model_ready()});
            check("m_err_cnt", {24'b0, err_cnt}, err_m);
            if (q.size() != 0) begin
                check("m_beat", {12'b0, out_imm, out_eop, out_last, out_err}, {12'b0, q[0]});
            end
        end
    end

    task automatic expect_beat(input string name, input logic [15:0] imm, input logic [1:0] eop,
                               input logic last, input logic err);
        check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({name, "_beat"}, {12'b0, out_imm, out_eop, out_last, out_err},
              {12'b0, imm, eop, last, err});
    endtask

    // Present one request and wait (bounded) for it to be accepted.
    task automatic send(input logic [31:0] v, input logic k);
        bit r;
        bit done;
        done = 1'b0;
        in_valid = 1'b1; in_value = v; in_kind = k;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); r = in_ready;
            @(posedge clk); #1;
            if (r) begin done = 1'b1; break; end
        end
        in_valid = 1'b0;
        check("accept_timeout", {31'b0, done}, 32'd1);
    endtask

    logic [31:0] b2b_v [4] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hABCD_0000};
    logic [19:0] b2b_e [4] = '{{16'h0005, 2'b00, 1'b1, 1'b0}, {16'hFFFF, 2'b00, 1'b1, 1'b0},
                               {16'hFFFF, 2'b01, 1'b1, 1'b0}, {16'hABCD, 2'b10, 1'b1, 1'b0}};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_fields", {12'b0, out_imm, out_eop, out_last, out_err}, 32'd0);
        check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;

        out_ready = 1'b1;
        send(32'hFFFF_8000, 1'b0); expect_beat("c_8000", 16'h8000, 2'b00, 1'b1, 1'b0);
        send(32'h0000_ABCD, 1'b0); expect_beat("c_abcd", 16'hABCD, 2'b01, 1'b1, 1'b0);
        send(32'h0000_7FFF, 1'b0); expect_beat("c_7fff", 16'h7FFF, 2'b00, 1'b1, 1'b0);
        send(32'h1234_0000, 1'b0); expect_beat("c_1234", 16'h1234, 2'b10, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("idle_after_singles", {31'b0, out_valid}, 32'd0);

        out_ready = 1'b0;
        send(32'h1234_5678, 1'b0);
        expect_beat("two_b0", 16'h1234, 2'b10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            expect_beat("two_hold", 16'h1234, 2'b10, 1'b0, 1'b0);
            check("two_hold_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        expect_beat("two_b1", 16'h5678, 2'b01, 1'b1, 1'b0);
        check("two_b1_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("idle_after_two", {31'b0, out_valid}, 32'd0);

        in_valid = 1'b1; in_kind = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_value = b2b_v[i];
            @(negedge clk);
            check("b2b_ready", {31'b0, in_ready}, 32'd1);
            @(posedge clk); #1;
            expect_beat("b2b", b2b_e[i][19:4], b2b_e[i][3:2], b2b_e[i][1], b2b_e[i][0]);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        send(32'hFFFF_FFF8, 1'b1); expect_beat("br_fff8", 16'hFFFE, 2'b11, 1'b1, 1'b0);
        send(32'h0001_FFFC, 1'b1); expect_beat("br_1fffc", 16'h7FFF, 2'b11, 1'b1, 1'b0);
        check("br_cnt0", {24'b0, err_cnt}, 32'd0);
        send(32'h0000_0006, 1'b1); expect_beat("br_err6", 16'h0000, 2'b00, 1'b1, 1'b1);
        check("br_cnt1", {24'b0, err_cnt}, 32'd1);
        send(32'h0002_0000, 1'b1); expect_beat("br_err2", 16'h0000, 2'b00, 1'b1, 1'b1);
        check("br_cnt2", {24'b0, err_cnt}, 32'd2);

        in_valid = 1'b1; in_kind = 1'b1; in_value = 32'h0000_0006;
        repeat (300) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        check("sat_cnt", {24'b0, err_cnt}, 32'hFF);
        @(posedge clk); #1;

        out_ready = 1'b0;
        send(32'hDEAD_BEEF, 1'b0);
        expect_beat("rst_b0", 16'hDEAD, 2'b10, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        expect_beat("rst_b1", 16'hBEEF, 2'b01, 1'b1, 1'b0);
        out_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_fields", {12'b0, out_imm, out_eop, out_last, out_err}, 32'd0);
        check("mid_rst_cnt", {24'b0, err_cnt}, 32'd0);
        check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        out_ready = 1'b1;
        send(32'h0000_0001, 1'b0); expect_beat("post_rst", 16'h0001, 2'b00, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("post_rst_idle", {31'b0, out_valid}, 32'd0);
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
